// File: rtl/apb_2_lint.sv
// apb_2_lint: APB3 completer that turns each APB transfer into one lint req/gnt/rvalid transaction.
// Latency: PSEL setup to PREADY is 3 cycles with gnt in the first REQ cycle and rvalid one cycle later.
// Backpressure: PREADY stays low while the lint side stalls; a timeout ends the transfer with PSLVERR.
module apb_2_lint #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  input  logic                  data_err_i
);

  // Counter is wide enough to hold TIMEOUT; a TIMEOUT of 0 keeps it parked at zero.
  localparam int              CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  tmo_hit;

  // The setup phase alone starts a request, so the access-phase strobe carries no information here.
  logic unused_penable;
  assign unused_penable = PENABLE;

  // Saturating REQ/WAIT cycle count and the cycle in which it reaches the limit
  always_comb begin
    cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
    tmo_hit = (TIMEOUT != 0) && (cnt_inc == TMO);
  end

  // Transfer sequencing: latch the APB request, run the lint handshake, present the result
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;

    // A response owed to a timed-out transfer is swallowed; the flag is only ever set
    // while the FSM sits in DONE/IDLE, so this never competes with a live response.
    if (drop_q && data_rvalid_i) begin
      drop_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (PSEL && !drop_q) begin
          addr_d  = PADDR;
          we_d    = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (tmo_hit) begin
          // A grant landing on the expiry cycle still commits the slave to a response,
          // which must then be discarded when it eventually shows up.
          rdata_d = '0;
          err_d   = 1'b1;
          drop_d  = data_gnt_i;
          state_d = DONE;
        end else if (data_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        // A response on the expiry cycle wins: nothing would be left to discard otherwise.
        if (data_rvalid_i) begin
          rdata_d = we_q ? '0 : data_rdata_i;
          err_d   = data_err_i;
          state_d = DONE;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded straight from registered state, so reset clears them at once.
  assign data_req_o   = (state_q == REQ);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_wdata_o = wdata_q;
  assign data_be_o    = {BE_WIDTH{1'b1}};
  assign PREADY       = (state_q == DONE);
  assign PSLVERR      = (state_q == DONE) && err_q;
  assign PRDATA       = rdata_q;

endmodule

// File: doc/apb_2_lint.md
Name: apb_2_lint

Overview:
- APB3 completer that converts each APB transfer into one lint (req/gnt/rvalid) initiator transaction, the reverse direction of lint_2_apb.
- Gives APB-side agents (debug/DMA/test APB port) access to memories and lint-attached slaves on the core data interconnect.
- One transaction outstanding at a time.
- Lint errors and a configurable response timeout are reported as PSLVERR.

Parameters:
ADDR_WIDTH, 32, APB and lint address width
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, lint byte-enable width
TIMEOUT, 255, cycles allowed in REQ+WAIT before error completion; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
PADDR  in  ADDR_WIDTH  APB address
PWDATA  in  DATA_WIDTH  APB write data
PWRITE  in  1  1=write
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PRDATA  out  DATA_WIDTH  read data, registered
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid with PREADY
data_req_o  out  1  lint request
data_addr_o  out  ADDR_WIDTH  lint address
data_we_o  out  1  1=write
data_be_o  out  BE_WIDTH  byte enables, always all ones
data_wdata_o  out  DATA_WIDTH  lint write data
data_gnt_i  in  1  lint grant
data_rvalid_i  in  1  lint response valid, for reads and writes
data_rdata_i  in  DATA_WIDTH  lint read data
data_err_i  in  1  lint error, sampled with rvalid

Behaviour:
Reset:
- All state is cleared asynchronously; FSM goes to IDLE.
- PRDATA=0, PREADY=0, PSLVERR=0, data_req_o=0, data_addr_o=0, data_we_o=0, data_wdata_o=0, data_be_o=all ones, drop flag=0, timeout counter=0.
- Reset mid-transaction abandons it immediately; data_req_o falls asynchronously.

FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Condition: PSEL=1 and drop flag=0.
  - Action: latch PADDR, PWDATA and PWRITE into the lint output registers, clear the counter, go to REQ.
  - PENABLE is not required, so the setup phase starts the request.
- REQ:
  - data_req_o=1 with stable address, write and data.
  - data_gnt_i=1 → WAIT (req deasserts the next cycle).
- WAIT:
  - data_req_o=0.
  - data_rvalid_i=1 → capture PRDATA = data_rdata_i for reads, 0 for writes.
  - Capture PSLVERR = data_err_i, then go to DONE.
- DONE:
  - PREADY=1 combinationally for exactly one cycle, then IDLE.
  - PRDATA and PSLVERR hold until the next DONE.
- PREADY=0 in all other states. PSLVERR is output only while PREADY=1; otherwise 0.

Latency:
- PSEL setup at cycle 0, gnt in cycle 1, rvalid in cycle 2 → PREADY=1 in cycle 3.
- Each added gnt or rvalid wait cycle adds one cycle.

Lint rules:
- At most one outstanding transaction.
- gnt is ignored outside REQ.
- rvalid is ignored outside WAIT, except a drop-flag discard (see Timeout).
- A same-cycle gnt+rvalid in REQ is treated as gnt only; the design requires rvalid at least 1 cycle after gnt.

Timeout (TIMEOUT≠0):
- The counter increments every cycle in REQ/WAIT and saturates.
- When it reaches TIMEOUT: go to DONE with PSLVERR=1, PRDATA=0.
- Timeout in REQ: data_req_o is withdrawn.
- Timeout in WAIT: set the drop flag. The next data_rvalid_i while in IDLE is discarded and clears the flag.
- New transfers stay in IDLE (PREADY=0) until the flag clears.

APB protocol violations:
- PSEL deasserted before DONE: the lint transaction still completes, DONE still lasts one cycle, and the result is discarded.
- PADDR/PWDATA changes after the latch are ignored.

Back-to-back transfers:
- PSEL held into the next setup phase in the cycle after DONE starts a new REQ from IDLE.
- Minimum APB transfer spacing is 4 cycles.

Test Plan:
1. Write: PADDR=0x0000_1004, PWDATA=0xDEAD_BEEF, gnt immediate, rvalid 1 cycle later → data_req_o 1 cycle with addr 0x1004, we=1, be=0xF, wdata 0xDEADBEEF; PREADY at cycle 3; PSLVERR=0.
2. Read with stalls: gnt after 3 cycles, rvalid 2 cycles after gnt with rdata=0x1234_5678 → addr/we stable across stall; PRDATA=0x12345678 with PREADY at cycle 7; PREADY high exactly 1 cycle.
3. Error: read, rvalid with data_err_i=1 → PREADY=1, PSLVERR=1.
4. Timeout: TIMEOUT=8, gnt never asserted → data_req_o drops after 8 cycles; PREADY=1, PSLVERR=1, PRDATA=0. Repeat with gnt given and rvalid withheld, then late rvalid=0xAAAA_AAAA → value discarded; next read stalls in IDLE until it arrives, then returns its own data.
5. Back-to-back: write 0x10 then read 0x10 with the APB master issuing immediately → two lint requests, correct ordering, second PREADY ≥4 cycles after first.
6. Reset asserted in WAIT → data_req_o, PREADY, PSLVERR, PRDATA=0 immediately; after release, a new read completes normally.
